// File: rtl/cordic_rotate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_rotate                                                |
// | Description : Pipelined CORDIC rotation engine. Rotates a signed Q4.8      |
// |               vector (in_x, in_y) by a 16-bit binary angle, one sample per |
// |               clock, carrying a valid bit and an ID tag in lockstep.       |
// |               Output is rounded half-up and saturated back to Q4.8.        |
// | Ports       : clock, reset (async, active-low)                             |
// |               in_valid/in_x/in_y/in_angle/in_id   : input sample           |
// |               out_valid/out_x/out_y/out_id        : rotated sample         |
// | Options     : CORDIC_ROTATE_GAIN_COMP_EN - adds one stage scaling by 1/K   |
// |               (latency STAGES+2 instead of STAGES+1).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_rotate #(
  parameter int WIDTH    = 12,
  parameter int ID_WIDTH = 8,
  parameter int STAGES   = 10,
  parameter int GUARD    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_y,
  input  logic [15:0]         in_angle,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_x,
  output logic [WIDTH-1:0]    out_y,
  output logic [ID_WIDTH-1:0] out_id
);

  // Two integer headroom bits absorb the CORDIC gain (|v| * sqrt2 * K < 4x).
  localparam int W = WIDTH + 2 + GUARD;
  localparam logic signed [W:0] SAT_MAX  = (W+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [W:0] SAT_MIN  = (W+1)'(-(1 << (WIDTH-1)));
  localparam logic signed [W:0] RND_HALF = (W+1)'(1 << (GUARD-1));

  function automatic logic signed [15:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = 16'sd8192;
      1:       atan_lut = 16'sd4836;
      2:       atan_lut = 16'sd2555;
      3:       atan_lut = 16'sd1297;
      4:       atan_lut = 16'sd651;
      5:       atan_lut = 16'sd326;
      6:       atan_lut = 16'sd163;
      7:       atan_lut = 16'sd81;
      8:       atan_lut = 16'sd41;
      9:       atan_lut = 16'sd20;
      10:      atan_lut = 16'sd10;
      11:      atan_lut = 16'sd5;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [W:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  // Index 0 is the quadrant pre-rotation register, index k (1..STAGES) holds
  // the result of micro-rotation k-1. The residual angle is not needed after
  // the last micro-rotation, so z stops one entry short.
  logic signed [W-1:0]  x_q     [0:STAGES];
  logic signed [W-1:0]  x_d     [0:STAGES];
  logic signed [W-1:0]  y_q     [0:STAGES];
  logic signed [W-1:0]  y_d     [0:STAGES];
  logic signed [15:0]   z_q     [0:STAGES-1];
  logic signed [15:0]   z_d     [0:STAGES-1];
  logic                 valid_q [0:STAGES];
  logic                 valid_d [0:STAGES];
  logic [ID_WIDTH-1:0]  id_q    [0:STAGES];
  logic [ID_WIDTH-1:0]  id_d    [0:STAGES];

  logic signed [W-1:0]  ext_x;
  logic signed [W-1:0]  ext_y;

  always_comb begin
    for (int k = 0; k <= STAGES; k++) begin
      x_d[k]     = '0;
      y_d[k]     = '0;
      valid_d[k] = 1'b0;
      id_d[k]    = '0;
    end
    for (int k = 0; k < STAGES; k++) begin
      z_d[k] = '0;
    end

    ext_x = {{(W-WIDTH){in_x[WIDTH-1]}}, in_x} << GUARD;
    ext_y = {{(W-WIDTH){in_y[WIDTH-1]}}, in_y} << GUARD;

    // Fold the angle into [-90, +90) degrees so the iterations converge.
    case (in_angle[15:14])
      2'b01: begin
        x_d[0] = -ext_y;
        y_d[0] = ext_x;
        z_d[0] = in_angle - 16'd16384;
      end
      2'b10: begin
        x_d[0] = ext_y;
        y_d[0] = -ext_x;
        z_d[0] = in_angle + 16'd16384;
      end
      default: begin
        x_d[0] = ext_x;
        y_d[0] = ext_y;
        z_d[0] = in_angle;
      end
    endcase
    valid_d[0] = in_valid;
    id_d[0]    = in_id;

    for (int i = 0; i < STAGES; i++) begin
      if (z_q[i][15]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
      end
      valid_d[i+1] = valid_q[i];
      id_d[i+1]    = id_q[i];
    end

    for (int i = 0; i < STAGES-1; i++) begin
      z_d[i+1] = z_q[i][15] ? (z_q[i] + atan_lut(i)) : (z_q[i] - atan_lut(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        valid_q[k] <= 1'b0;
        id_q[k]    <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        z_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= STAGES; k++) begin
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        valid_q[k] <= valid_d[k];
        id_q[k]    <= id_d[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        z_q[k] <= z_d[k];
      end
    end
  end

  logic signed [W-1:0]  fin_x;
  logic signed [W-1:0]  fin_y;
  logic                 fin_valid;
  logic [ID_WIDTH-1:0]  fin_id;

`ifdef CORDIC_ROTATE_GAIN_COMP_EN
  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 = 0.60718
  logic signed [W-1:0]  gain_x_q, gain_x_d;
  logic signed [W-1:0]  gain_y_q, gain_y_d;
  logic                 gain_valid_q, gain_valid_d;
  logic [ID_WIDTH-1:0]  gain_id_q, gain_id_d;

  always_comb begin
    gain_x_d = (x_q[STAGES] >>> 1) + (x_q[STAGES] >>> 3) - (x_q[STAGES] >>> 6)
             - (x_q[STAGES] >>> 9) - (x_q[STAGES] >>> 12);
    gain_y_d = (y_q[STAGES] >>> 1) + (y_q[STAGES] >>> 3) - (y_q[STAGES] >>> 6)
             - (y_q[STAGES] >>> 9) - (y_q[STAGES] >>> 12);
    gain_valid_d = valid_q[STAGES];
    gain_id_d    = id_q[STAGES];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gain_x_q     <= '0;
      gain_y_q     <= '0;
      gain_valid_q <= 1'b0;
      gain_id_q    <= '0;
    end else begin
      gain_x_q     <= gain_x_d;
      gain_y_q     <= gain_y_d;
      gain_valid_q <= gain_valid_d;
      gain_id_q    <= gain_id_d;
    end
  end

  always_comb begin
    fin_x     = gain_x_q;
    fin_y     = gain_y_q;
    fin_valid = gain_valid_q;
    fin_id    = gain_id_q;
  end
`else
  always_comb begin
    fin_x     = x_q[STAGES];
    fin_y     = y_q[STAGES];
    fin_valid = valid_q[STAGES];
    fin_id    = id_q[STAGES];
  end
`endif

  // Round half-up, drop guard bits, clamp to the Q4.8 range. A cleared
  // pipeline rounds to exactly zero, so outputs read 0 during reset.
  logic signed [W:0] rnd_x;
  logic signed [W:0] rnd_y;

  always_comb begin
    rnd_x     = ($signed({fin_x[W-1], fin_x}) + RND_HALF) >>> GUARD;
    rnd_y     = ($signed({fin_y[W-1], fin_y}) + RND_HALF) >>> GUARD;
    out_x     = sat(rnd_x);
    out_y     = sat(rnd_y);
    out_valid = fin_valid;
    out_id    = fin_id;
  end

endmodule
`default_nettype wire

// File: doc/cordic_rotate.md
Name: cordic_rotate

Overview:
- Pipelined CORDIC rotation engine.
- Consumes Q4.8 vector components produced by the upstream scaling stage and rotates each vector by a binary-angle input.
- Carries an ID tag and a valid bit alongside the data. Accepts one vector per clock with no backpressure.
- Sits directly downstream of scaling in the ray-direction transform path.

Parameters:
- WIDTH, 12, data width of in/out x,y, signed Q4.8.
- ID_WIDTH, 8, width of ID tag carried with each sample.
- STAGES, 10, number of CORDIC micro-rotation iterations; legal range 4..12.
- GUARD, 3, extra LSBs carried internally below the Q4.8 point.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_x  in  WIDTH  signed Q4.8 x component.
- in_y  in  WIDTH  signed Q4.8 y component.
- in_angle  in  16  binary angle: 65536 counts = 2π, two's complement, so 16384 = +90° and -32768 = 180°.
- in_id  in  ID_WIDTH  sample tag.
- out_valid  out  1  output sample valid.
- out_x  out  WIDTH  rotated x, signed Q4.8, saturated.
- out_y  out  WIDTH  rotated y, signed Q4.8, saturated.
- out_id  out  ID_WIDTH  tag matching out_x/out_y.

Behaviour:
- Reset (reset=0, asynchronous): every pipeline register clears. out_valid=0, out_x=0, out_y=0, out_id=0. Reset asserted mid-stream discards all in-flight samples. The first valid output after release appears LATENCY cycles after the first in_valid sampled with reset high.
- Throughput and latency: one sample per clock, no stall. LATENCY = 1 pre-rotation stage + STAGES iteration stages = 11 by default. Valid, ID and data advance in lockstep. Bubbles (in_valid=0) propagate as out_valid=0. Data registers update every cycle regardless of valid.
- Internal datapath width: W = WIDTH+2 integer headroom + GUARD fractional bits. Inputs are sign-extended and left-shifted by GUARD.
- Stage 0, quadrant pre-rotation on in_angle[15:14]:
  - 00 or 11: pass unchanged.
  - 01: (x,y) -> (-y,x), angle -= 16384.
  - 10: (x,y) -> (y,-x), angle += 16384.
  - Residual angle lies in [-16384, 16383].
- Stage i (i=0..STAGES-1): d = +1 if residual z >= 0, else -1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*ATAN[i]
  - Shifts are arithmetic.
- ATAN table in binary-angle units, indices 0..11: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
- Output conversion: round-half-up by adding 1<<(GUARD-1), then drop GUARD LSBs. Saturate to [-2048, 2047]. The result carries CORDIC gain K≈1.6468 unless the optional feature is enabled.
- Angle arithmetic is 16-bit and wraps modulo 2^16. in_angle=-32768 is treated as quadrant 10.
- Zero input vector yields exactly 0,0 for any angle.

Optional Feature:
- CORDIC_ROTATE_GAIN_COMP_EN
- Defined:
  - One extra pipeline stage multiplies x and y by 1/K via shift-add: v*(2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12) ≈ 0.6072 v, computed at internal width before rounding and saturation.
  - LATENCY becomes STAGES+2 (12 by default).
  - Output magnitude ≈ input magnitude.
- Undefined: no compensation stage; LATENCY = STAGES+1; output carries gain K.

Test Plan:
- x=256, y=0, angle=0, id=1 -> 11 cycles later out_valid=1, out_id=1, out_x=422±2, out_y=0±2.
- x=256, y=0, angle=16384 -> out_x=0±2, out_y=422±2. Same input with angle=-32768 -> out_x=-422±2, out_y=0±2.
- Saturation: x=y=2000, angle=8192 (45°) -> out_x=0±3, out_y=2047.
- Throughput: 12 back-to-back samples, ids 1..12, with in_valid deasserted for one cycle after id 6 -> outputs emerge in order on consecutive cycles with exactly one out_valid=0 bubble. Each sample within ±3 LSB of the real-valued K·rotation.
- Reset mid-stream: drive reset=0 between clock edges while 5 samples are in flight -> out_valid, out_x, out_y, out_id are 0 immediately. After release, no stale samples emerge.
- With CORDIC_ROTATE_GAIN_COMP_EN: x=256, y=0, angle=0 -> out_x=256±3 after 12 cycles.
